// File: rtl/temporal_ngram_encoder_if.sv
// Valid/ready bundle between the spatial encoder, the n-gram encoder and the AM.
// FlushIn_SI exists only when NGRAM_FLUSH_EN is defined.
interface temporal_ngram_encoder_if #(
   parameter int HV_DIMENSION = 2000
);
   logic                    ValidIn_SI;
   logic                    ReadyOut_SO;
   logic [0:HV_DIMENSION-1] HypervectorIn_DI;
   logic                    ValidOut_SO;
   logic                    ReadyIn_SI;
   logic [0:HV_DIMENSION-1] HypervectorOut_DO;
`ifdef NGRAM_FLUSH_EN
   logic                    FlushIn_SI;

   modport slave (
      input  ValidIn_SI, HypervectorIn_DI, ReadyIn_SI, FlushIn_SI,
      output ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
   );
   modport master (
      output ValidIn_SI, HypervectorIn_DI, ReadyIn_SI, FlushIn_SI,
      input  ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
   );
`else
   modport slave (
      input  ValidIn_SI, HypervectorIn_DI, ReadyIn_SI,
      output ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
   );
   modport master (
      output ValidIn_SI, HypervectorIn_DI, ReadyIn_SI,
      input  ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
   );
`endif
endinterface

// File: rtl/temporal_ngram_encoder.sv
// Binds the last NGRAM_SIZE spatial HVs (rotate + XOR) into one AM query, valid the cycle after accept.
// Query is held while ReadyIn_SI=0 and no input is taken meanwhile; NGRAM_FLUSH_EN adds a history flush.
module temporal_ngram_encoder #(
   parameter int HV_DIMENSION = 2000,
   parameter int NGRAM_SIZE   = 3
) (
   input  logic                    Clk_CI,
   input  logic                    Reset_RI,
   temporal_ngram_encoder_if.slave bus
);
   localparam int               CNT_W    = $clog2(NGRAM_SIZE);
   localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(NGRAM_SIZE - 1);

   typedef enum logic {IDLE = 1'b0, OUTPUT_STABLE = 1'b1} state_e;

   state_e                  state_q, state_d;
   logic [0:HV_DIMENSION-1] history_q [1:NGRAM_SIZE-1];
   logic [0:HV_DIMENSION-1] history_d [1:NGRAM_SIZE-1];
   logic [CNT_W-1:0]        fill_cntr_q, fill_cntr_d;
   logic [0:HV_DIMENSION-1] hv_out_q, hv_out_d;
   logic [0:HV_DIMENSION-1] acc, ngram;
   logic                    flush, ready_out, accept;

   // rho(x)[i] = x[i-1]: the last bit wraps around into bit 0.
   function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] x);
      return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
   endfunction

`ifdef NGRAM_FLUSH_EN
   assign flush = bus.FlushIn_SI;
`else
   assign flush = 1'b0;
`endif

   assign ready_out = (state_q == IDLE) && !flush;
   assign accept    = ready_out && bus.ValidIn_SI;

   assign bus.ReadyOut_SO       = ready_out;
   assign bus.ValidOut_SO       = (state_q == OUTPUT_STABLE);
   assign bus.HypervectorOut_DO = hv_out_q;

   // Horner form: rho(H1) ^ rho^2(H2) ^ ... == rho(H1 ^ rho(H2 ^ ...)), one rotation per stage.
   always_comb begin
      acc = history_q[NGRAM_SIZE-1];
      for (int k = NGRAM_SIZE - 2; k >= 1; k--) begin
         acc = history_q[k] ^ rho(acc);
      end
      ngram = bus.HypervectorIn_DI ^ rho(acc);
   end

   always_comb begin
      state_d     = state_q;
      history_d   = history_q;
      fill_cntr_d = fill_cntr_q;
      hv_out_d    = hv_out_q;

      if (state_q == OUTPUT_STABLE && bus.ReadyIn_SI) begin
         state_d = IDLE;
      end

      if (flush) begin
         for (int k = 1; k < NGRAM_SIZE; k++) begin
            history_d[k] = '0;
         end
         fill_cntr_d = '0;
      end else if (accept) begin
         for (int k = NGRAM_SIZE - 1; k > 1; k--) begin
            history_d[k] = history_q[k-1];
         end
         history_d[1] = bus.HypervectorIn_DI;
         if (fill_cntr_q < FILL_MAX) begin
            fill_cntr_d = fill_cntr_q + 1'b1;
         end else begin
            hv_out_d = ngram;
            state_d  = OUTPUT_STABLE;
         end
      end
   end

   always_ff @(posedge Clk_CI or posedge Reset_RI) begin
      if (Reset_RI) begin
         state_q     <= IDLE;
         fill_cntr_q <= '0;
         hv_out_q    <= '0;
         for (int k = 1; k < NGRAM_SIZE; k++) begin
            history_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         fill_cntr_q <= fill_cntr_d;
         hv_out_q    <= hv_out_d;
         history_q   <= history_d;
      end
   end
endmodule
